// File: rtl/thread_pc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : thread_pc_scheduler
// Brief    : Barrel-thread round-robin issue with a per-thread PC table and
//            execute-stage redirects; registered PC/TID drive the I-BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module thread_pc_scheduler #(
  parameter int                    NUM_THREADS  = 32,
  parameter int                    ADDR_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0] STARTUP_ADDR = '0,
  parameter int                    TID_WIDTH    = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_stall,
  input  logic [NUM_THREADS-1:0] i_thread_en,
  input  logic                   i_redirect_valid,
  input  logic [TID_WIDTH-1:0]   i_redirect_tid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_valid,
  output logic [TID_WIDTH-1:0]   o_tid,
  output logic [ADDR_WIDTH-1:0]  o_pc
);

  localparam logic [TID_WIDTH-1:0] c_last_tid = TID_WIDTH'(NUM_THREADS - 1);

  logic [ADDR_WIDTH-1:0] r_pc_table [NUM_THREADS];
  logic [TID_WIDTH-1:0]  r_tid;
  logic                  r_valid;
  logic [TID_WIDTH-1:0]  r_out_tid;
  logic [ADDR_WIDTH-1:0] r_out_pc;

  logic                  w_redirect_cur;
  logic [ADDR_WIDTH-1:0] w_sel_pc;
  logic [ADDR_WIDTH-1:0] w_sel_pc_inc;
  logic                  w_cur_en;

  // A redirect aimed at the thread being issued right now bypasses the table.
  assign w_redirect_cur = i_redirect_valid && (i_redirect_tid == r_tid);
  assign w_sel_pc       = w_redirect_cur ? i_redirect_pc : r_pc_table[r_tid];
  assign w_sel_pc_inc   = w_sel_pc + ADDR_WIDTH'(1);
  assign w_cur_en       = i_thread_en[r_tid];

  // Out-of-range redirect TIDs match no entry and are dropped naturally.
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_pc_entry
    logic w_issue_here;
    logic w_redirect_here;

    assign w_issue_here    = !i_stall && (r_tid == TID_WIDTH'(t));
    assign w_redirect_here = i_redirect_valid && (i_redirect_tid == TID_WIDTH'(t));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_pc_table[t] <= STARTUP_ADDR;
      end else if (w_issue_here) begin
        r_pc_table[t] <= i_thread_en[t] ? w_sel_pc_inc : w_sel_pc;
      end else if (w_redirect_here) begin
        r_pc_table[t] <= i_redirect_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tid     <= '0;
      r_valid   <= 1'b0;
      r_out_tid <= '0;
      r_out_pc  <= '0;
    end else if (i_stall) begin
      r_valid   <= 1'b0;
    end else begin
      r_tid     <= (r_tid == c_last_tid) ? '0 : r_tid + TID_WIDTH'(1);
      r_valid   <= w_cur_en;
      r_out_tid <= r_tid;
      r_out_pc  <= w_sel_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_tid   = r_out_tid;
  assign o_pc    = r_out_pc;

endmodule
`default_nettype wire
